// File: rtl/npu_fp_pkg.sv
// Shared fp32 types and constants for the NPU v2 datapath.
// Holds the accumulation sequencer state encoding.
package npu_fp_pkg;

  typedef struct packed {
    logic       sign;
    logic [7:0] exponent;
    logic [22:0] fraction;
  } fp32_t;

  localparam logic [31:0] FP32_QNAN = 32'h7FC00000;
  localparam logic [31:0] FP32_ONE  = 32'h3F800000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HOLD,
    S_ISSUE,
    S_WAIT,
    S_OUT
  } acc_state_e;

endpackage

// File: rtl/fp32_acc_sequencer.sv
// Group reduction sequencer: feeds (sum, element) pairs to an
// external fp32 adder and emits one sum and count per group.
module fp32_acc_sequencer
  import npu_fp_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      i_data,
  input  logic             i_last,
  input  logic             i_valid,
  output logic             i_ready,
  output logic [31:0]      add_a,
  output logic [31:0]      add_b,
  output logic             add_in_valid,
  input  logic             add_in_ready,
  input  logic [31:0]      add_result,
  input  logic             add_out_valid,
  output logic             add_out_ready,
  output logic [31:0]      o_sum,
  output logic [CNT_W-1:0] o_count,
  output logic             o_valid,
  input  logic             o_ready
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  acc_state_e       r_state;
  acc_state_e       w_next;
  fp32_t            r_acc;
  logic [31:0]      r_xr;
  logic             r_last;
  logic [CNT_W-1:0] r_cnt;

  logic w_in_hs;
  logic w_res_hs;

  assign w_in_hs  = i_valid & i_ready;
  assign w_res_hs = add_out_valid & add_out_ready;

  // Operands and results always reflect the registers, never X.
  assign add_a   = r_acc;
  assign add_b   = r_xr;
  assign o_sum   = r_acc;
  assign o_count = r_cnt;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    w_next        = r_state;
    i_ready       = 1'b0;
    add_in_valid  = 1'b0;
    add_out_ready = 1'b0;
    o_valid       = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        i_ready = 1'b1;
        if (i_valid) w_next = i_last ? S_OUT : S_HOLD;
      end
      S_HOLD: begin
        i_ready = 1'b1;
        if (i_valid) w_next = S_ISSUE;
      end
      S_ISSUE: begin
        add_in_valid = 1'b1;
        if (add_in_ready) w_next = S_WAIT;
      end
      S_WAIT: begin
        add_out_ready = 1'b1;
        if (add_out_valid) w_next = r_last ? S_OUT : S_HOLD;
      end
      S_OUT: begin
        o_valid = 1'b1;
        if (o_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath: first element seeds the sum, later ones go via the adder.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_acc  <= '0;
      r_xr   <= '0;
      r_last <= 1'b0;
      r_cnt  <= '0;
    end else begin
      if (w_in_hs && r_state == S_IDLE) begin
        r_acc <= i_data;
        r_cnt <= {{(CNT_W-1){1'b0}}, 1'b1};
      end
      if (w_in_hs && r_state == S_HOLD) begin
        r_xr   <= i_data;
        r_last <= i_last;
        if (r_cnt != CNT_MAX) r_cnt <= r_cnt + 1'b1;
      end
      if (w_res_hs) begin
        r_acc <= add_result;
      end
    end
  end

endmodule

// File: tb/tb_fp32_acc_sequencer.sv
// Scoreboard bench for fp32_acc_sequencer with a behavioural
// variable-latency adder attached.
module tb_fp32_acc_sequencer;

  localparam int CNT_W = 4;
  localparam int LAT   = 2;

  logic             clk = 0;
  logic             rst_n = 0;
  logic [31:0]      i_data = '0;
  logic             i_last = 0;
  logic             i_valid = 0;
  logic             i_ready;
  logic [31:0]      add_a, add_b;
  logic             add_in_valid;
  logic             add_in_ready;
  logic [31:0]      add_result;
  logic             add_out_valid;
  logic             add_out_ready;
  logic [31:0]      o_sum;
  logic [CNT_W-1:0] o_count;
  logic             o_valid;
  logic             o_ready = 1;

  int n_pass = 0;
  int n_total = 0;

  typedef struct packed {
    logic [31:0]      sum;
    logic [CNT_W-1:0] cnt;
  } exp_t;
  exp_t exp_q[$];

  fp32_acc_sequencer #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_data(i_data), .i_last(i_last),
    .i_valid(i_valid), .i_ready(i_ready),
    .add_a(add_a), .add_b(add_b),
    .add_in_valid(add_in_valid), .add_in_ready(add_in_ready),
    .add_result(add_result), .add_out_valid(add_out_valid),
    .add_out_ready(add_out_ready),
    .o_sum(o_sum), .o_count(o_count),
    .o_valid(o_valid), .o_ready(o_ready)
  );

  always #5 clk = ~clk;

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, req);
  endtask

  // ---- behavioural adder (exact for the small values used) ----
  function automatic real f2r(logic [31:0] f);
    real m, r;
    int e;
    if (f[30:23] == 8'd0) return 0.0;
    m = 1.0 + real'(f[22:0]) / 8388608.0;
    e = int'(f[30:23]) - 127;
    r = m;
    if (e > 0) for (int i = 0; i < e; i++) r = r * 2.0;
    else for (int i = 0; i < -e; i++) r = r / 2.0;
    return f[31] ? -r : r;
  endfunction

  function automatic logic [31:0] r2f(real r);
    logic [63:0] d;
    int e;
    logic [7:0] e8;
    if (r == 0.0) return 32'h0;
    d = $realtobits(r);
    e = int'(d[62:52]) - 896;
    e8 = e[7:0];
    return {d[63], e8, d[51:29]};
  endfunction

  logic        stall = 0;
  logic        busy, ov;
  logic [31:0] ra;
  int          lat_cnt;
  int          ntx = 0;
  logic        inj = 0;
  logic [31:0] inj_val = '0;

  assign add_in_ready  = !stall && !busy;
  assign add_out_valid = ov | inj;
  assign add_result    = inj ? inj_val : ra;

  always @(posedge clk) begin
    if (!rst_n) begin
      busy <= 0; ov <= 0; ra <= '0; lat_cnt <= 0;
    end else if (add_in_valid && add_in_ready) begin
      busy <= 1;
      ra <= r2f(f2r(add_a) + f2r(add_b));
      lat_cnt <= LAT - 1;
      ntx <= ntx + 1;
    end else if (busy && !ov) begin
      if (lat_cnt == 0) ov <= 1;
      else lat_cnt <= lat_cnt - 1;
    end else if (ov && add_out_ready) begin
      ov <= 0; busy <= 0;
    end
  end

  // ---- monitor: compare each accepted group result ----
  logic seen_aiv = 0;
  always @(negedge clk) begin
    if (add_in_valid) seen_aiv <= 1;
    if (rst_n && o_valid && o_ready) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_out: got %h/%0d expected none",
                 o_sum, o_count);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("o_sum", o_sum, e.sum);
        check("o_count", 32'(o_count), 32'(e.cnt));
      end
    end
  end

  // ---- stimulus helpers ----
  task automatic send(logic [31:0] d, logic l);
    int k;
    @(posedge clk); #1;
    i_data = d; i_last = l; i_valid = 1;
    k = 0;
    @(negedge clk);
    while (!i_ready && k < 200) begin
      @(negedge clk); k++;
    end
    if (!i_ready) begin
      n_total++;
      $display("FAIL send_timeout: i_ready 0 expected 1");
    end
    @(posedge clk); #1;
    i_valid = 0;
  endtask

  task automatic drain(string name);
    int k = 0;
    while (exp_q.size() != 0 && k < 500) begin
      @(negedge clk); k++;
    end
    @(negedge clk);
    if (exp_q.size() != 0) begin
      n_total++;
      $display("FAIL %s_timeout: %0d pending expected 0",
               name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic wait_neg(string name, ref logic sig);
    int k = 0;
    @(negedge clk);
    while (!sig && k < 200) begin
      @(negedge clk); k++;
    end
    if (!sig) begin
      n_total++;
      $display("FAIL %s_timeout: signal 0 expected 1", name);
    end
  endtask

  initial begin
    int t0;
    logic [31:0] ca, cb, cs;
    logic [CNT_W-1:0] cc;

    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    @(negedge clk);
    check("rst_i_ready", 32'(i_ready), 1);
    check("rst_o_valid", 32'(o_valid), 0);
    check("rst_add_in_valid", 32'(add_in_valid), 0);

    // three-element group: 1 + 2 + 3
    t0 = ntx;
    exp_q.push_back('{32'h40C00000, 4'd3});
    send(32'h3F800000, 0);
    send(32'h40000000, 0);
    send(32'h40400000, 1);
    drain("grp3");
    check("grp3_ntx", 32'(ntx - t0), 2);

    // single element passes bit-exact, no adder use
    t0 = ntx;
    seen_aiv = 0;
    exp_q.push_back('{32'hC0F00000, 4'd1});
    send(32'hC0F00000, 1);
    drain("single");
    check("single_no_add", 32'(seen_aiv), 0);
    check("single_ntx", 32'(ntx - t0), 0);

    // downstream backpressure in S_OUT
    o_ready = 0;
    exp_q.push_back('{32'h40000000, 4'd1});
    send(32'h40000000, 1);
    wait_neg("out_wait", o_valid);
    for (int i = 0; i < 5; i++) begin
      check("hold_o_valid", 32'(o_valid), 1);
      check("hold_o_sum", o_sum, 32'h40000000);
      check("hold_o_count", 32'(o_count), 1);
      check("hold_i_ready", 32'(i_ready), 0);
      @(negedge clk);
    end
    @(posedge clk); #1 o_ready = 1;
    @(negedge clk);
    @(negedge clk);
    check("release_i_ready", 32'(i_ready), 1);
    exp_q.push_back('{32'h3F800000, 4'd1});
    send(32'h3F800000, 1);
    drain("release");

    // adder input stall
    stall = 1;
    exp_q.push_back('{32'h40400000, 4'd2});
    send(32'h3F800000, 0);
    send(32'h40000000, 1);
    wait_neg("issue_wait", add_in_valid);
    ca = add_a; cb = add_b;
    check("issue_a", ca, 32'h3F800000);
    check("issue_b", cb, 32'h40000000);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("stall_valid", 32'(add_in_valid), 1);
      check("stall_a", add_a, ca);
      check("stall_b", add_b, cb);
    end
    @(posedge clk); #1 stall = 0;
    drain("stall");

    // spurious adder result while holding
    exp_q.push_back('{32'h40800000, 4'd2});
    send(32'h40000000, 0);
    @(posedge clk); #1;
    inj = 1; inj_val = 32'hDEADBEEF;
    @(negedge clk);
    check("inj_out_ready", 32'(add_out_ready), 0);
    @(posedge clk); #1 inj = 0;
    @(negedge clk);
    check("inj_acc", add_a, 32'h40000000);
    send(32'h40000000, 1);
    drain("inj");

    // twenty ones, count saturates
    exp_q.push_back('{32'h41A00000, 4'hF});
    for (int i = 0; i < 20; i++) send(32'h3F800000, i == 19);
    drain("sat");

    // reset while waiting on the adder
    send(32'h3F800000, 0);
    send(32'h40000000, 0);
    wait_neg("wait_state", add_out_ready);
    @(posedge clk); #1 rst_n = 0;
    @(posedge clk); #1 rst_n = 1;
    @(negedge clk);
    check("rst2_i_ready", 32'(i_ready), 1);
    check("rst2_add_in_valid", 32'(add_in_valid), 0);
    check("rst2_add_out_ready", 32'(add_out_ready), 0);
    check("rst2_o_valid", 32'(o_valid), 0);
    check("rst2_o_sum", o_sum, 0);
    check("rst2_o_count", 32'(o_count), 0);
    check("rst2_add_a", add_a, 0);
    check("rst2_add_b", add_b, 0);
    exp_q.push_back('{32'h40A00000, 4'd1});
    send(32'h40A00000, 1);
    drain("post_rst");

    cs = o_sum; cc = o_count;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fp32_acc_sequencer.md
Name: fp32_acc_sequencer

Overview:
- Upstream controller for the two-stage fp32 adder. Reduces a stream of fp32 values, grouped by a last flag, into one fp32 sum per group.
- Feeds the adder one (running sum, new element) pair at a time and writes the result back. Emits the final sum and the element count through a valid/ready output.
- Sits between the PE partial-sum stream and the output writeback in the NPU v2 datapath.
- The adder is instantiated by the parent. This block only drives and consumes its handshake ports.

Parameters:
- CNT_W, 16, width of the element counter and of o_count.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset. One clock; reset is synchronous and active-low.
- i_data  in  32  fp32 element
- i_last  in  1  marks the final element of a group
- i_valid  in  1  element valid
- i_ready  out  1  element accepted when i_valid & i_ready
- add_a  out  32  adder operand a (running sum)
- add_b  out  32  adder operand b (captured element)
- add_in_valid  out  1  operand pair valid
- add_in_ready  in  1  adder accepts pair
- add_result  in  32  adder sum
- add_out_valid  in  1  adder result valid
- add_out_ready  out  1  sequencer accepts result
- o_sum  out  32  final group sum
- o_count  out  CNT_W  number of elements in the group, saturating
- o_valid  out  1  group result valid
- o_ready  in  1  downstream accepts group result

Behaviour:
- FSM states: S_IDLE, S_HOLD, S_ISSUE, S_WAIT, S_OUT.
  - S_IDLE: no group open.
  - S_HOLD: group open, waiting for the next element.
- Registers: acc (32b), xr (32b), last_r, cnt (CNT_W).
- Reset (rst_n low at a clk edge):
  - state goes to S_IDLE; acc, xr, last_r and cnt clear to 0.
  - Outputs: i_ready=1, add_in_valid=0, add_out_ready=0, o_valid=0, o_sum=0, o_count=0, add_a=0, add_b=0.
  - Reset mid-group discards the partial sum.
  - The adder shares rst_n, so no stale adder result survives reset.
- i_ready = 1 in S_IDLE and S_HOLD only.
- S_IDLE, on input handshake:
  - acc <= i_data (bit-exact, including -0, NaN and subnormals). No adder transaction is issued.
  - cnt <= 1.
  - If i_last, go to S_OUT; else go to S_HOLD.
- S_HOLD, on input handshake:
  - xr <= i_data; last_r <= i_last.
  - cnt <= cnt+1, saturating at 2^CNT_W-1.
  - Go to S_ISSUE.
- S_ISSUE:
  - add_in_valid=1, add_a=acc, add_b=xr, held stable until add_in_ready.
  - On add_in_valid & add_in_ready, go to S_WAIT.
- S_WAIT:
  - add_out_ready=1.
  - On add_out_valid: acc <= add_result. Go to S_OUT if last_r, else S_HOLD.
  - Adder latency is arbitrary (≥1 cycle). The design must not rely on the fixed 2-stage depth.
- S_OUT:
  - o_valid=1, o_sum=acc, o_count=cnt, all held stable until o_ready.
  - On o_ready, go to S_IDLE. The next group may be accepted no earlier than the following cycle.
- At most one adder transaction is in flight.
- add_out_ready=0 outside S_WAIT. An unexpected add_out_valid in another state is not consumed; the adder stalls.
- add_in_valid=0 and add_a/add_b are don't-care outside S_ISSUE, but are driven with acc/xr (no X).
- Throughput: one element per (1 + adder latency + handshake) cycles after the first element of a group.
- No arithmetic is performed here. Special values propagate through the adder unchanged.

Decomposition:
- Shared package npu_fp_pkg holds:
  - fp32_t packed struct (sign, exponent[7:0], fraction[22:0]);
  - FP32_QNAN = 32'h7FC00000;
  - FP32_ONE = 32'h3F800000;
  - acc_state_e enum.
- No sub-module. The saturating counter and FSM live in this module; fp32_adder is instantiated alongside by the parent.

Test Plan:
- Group 3F800000, 40000000, 40400000 (last), with adder attached → o_sum 40C00000 (6.0), o_count 3, exactly 2 adder transactions.
- Single element C0F00000 with i_last=1 → o_sum C0F00000 bit-exact, o_count 1, add_in_valid never asserted.
- Hold o_ready low 5 cycles in S_OUT → o_valid, o_sum and o_count stable, i_ready=0. Release → back in S_IDLE next cycle; the next group's first element is accepted.
- Force add_in_ready low 4 cycles in S_ISSUE → add_a/add_b stable, add_in_valid held. Inject add_out_valid while in S_HOLD → add_out_ready=0, acc unchanged.
- CNT_W=4, twenty 3F800000 elements, last on the 20th → o_sum 41A00000 (20.0), o_count 4'hF (saturated).
- Assert rst_n low for one cycle while in S_WAIT after 2 elements → all outputs at reset values. A new group 40A00000 (last) → o_sum 40A00000, o_count 1.
